// File: rtl/mpc_io_pkg.sv
// Shared types, widths and the vertical routing table used by both the
// output selector and the pad-to-macro distributor.
package mpc_io_pkg;

    localparam int NORTH_W = 10;
    localparam int SIDE_W  = 14;
    localparam int CFG_W   = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        QUIET  = 2'd1,
        SETTLE = 2'd2
    } dist_state_e;

    // Macro index selected for a vertical position; unknown cfg values map to 0.
    function automatic logic [SEL_W-1:0] sel_for(input int pos, input logic [CFG_W-1:0] cfg);
        logic [SEL_W-1:0] sel;
        sel = '0;
        case (pos)
            0: case (cfg)
                4'd1:    sel = 2'd2;
                4'd2:    sel = 2'd1;
                4'd3:    sel = 2'd2;
                default: sel = 2'd0;
            endcase
            1: case (cfg)
                4'd2:    sel = 2'd1;
                4'd3:    sel = 2'd1;
                default: sel = 2'd0;
            endcase
            2: case (cfg)
                4'd0:    sel = 2'd2;
                4'd2:    sel = 2'd2;
                4'd3:    sel = 2'd1;
                default: sel = 2'd0;
            endcase
            default: sel = 2'd0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_sync_stage.sv
// Reset-to-zero flop chain bringing an asynchronous pad bus into the clk domain.
module io_sync_stage #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/vertical_distributor.sv
// Routes synchronised pad inputs to the macro chosen by the active configuration,
// forcing all macro inputs to zero while a configuration change is quieted and settled.
module vertical_distributor
    import mpc_io_pkg::*;
#(
    parameter int n             = 2,
    parameter int position      = 0,
    parameter int SYNC_STAGES   = 2,
    parameter int QUIET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CFG_W-1:0]               cfg_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    output logic [CFG_W-1:0]               cfg_active_o,
    output logic                           quiet_o,
    input  logic [NORTH_W-1:0]             north_i,
    input  logic [SIDE_W-1:0]              west_i,
    input  logic [SIDE_W-1:0]              east_i,
    output logic [n-1:0][NORTH_W-1:0]      north_i_buf,
    output logic [n:0][SIDE_W-1:0]         west_i_buf,
    output logic [n:0][SIDE_W-1:0]         east_i_buf
);

    localparam int CNT_MAX = (QUIET_CYCLES > SETTLE_CYCLES) ? QUIET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (n != 2 || position < 0 || position > 2 || SYNC_STAGES < 1 ||
            QUIET_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_param
            $error("vertical_distributor: unsupported parameter set");
        end
    endgenerate

    dist_state_e                  r_state;
    dist_state_e                  w_state_next;
    logic [CNT_W-1:0]             r_cnt;
    logic [CFG_W-1:0]             r_pending;
    logic [CFG_W-1:0]             r_cfg_active;
    logic [SEL_W-1:0]             r_sel;

    logic [NORTH_W-1:0]           w_north_sync;
    logic [SIDE_W-1:0]            w_west_sync;
    logic [SIDE_W-1:0]            w_east_sync;
    logic [n-1:0][NORTH_W-1:0]    w_north_route;
    logic [n:0][SIDE_W-1:0]       w_west_route;
    logic [n:0][SIDE_W-1:0]       w_east_route;
    logic [n-1:0][NORTH_W-1:0]    r_north_buf;
    logic [n:0][SIDE_W-1:0]       r_west_buf;
    logic [n:0][SIDE_W-1:0]       r_east_buf;

    io_sync_stage #(.WIDTH(NORTH_W), .STAGES(SYNC_STAGES)) u_sync_north (
        .clk(clk), .rst(rst), .d(north_i), .q(w_north_sync)
    );
    io_sync_stage #(.WIDTH(SIDE_W), .STAGES(SYNC_STAGES)) u_sync_west (
        .clk(clk), .rst(rst), .d(west_i), .q(w_west_sync)
    );
    io_sync_stage #(.WIDTH(SIDE_W), .STAGES(SYNC_STAGES)) u_sync_east (
        .clk(clk), .rst(rst), .d(east_i), .q(w_east_sync)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (cfg_valid_i)          w_state_next = QUIET;
            QUIET:   if (r_cnt == QUIET_LAST)  w_state_next = SETTLE;
            SETTLE:  if (r_cnt == SETTLE_LAST) w_state_next = RUN;
            default: w_state_next = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SETTLE;
            r_cnt        <= '0;
            r_pending    <= '0;
            r_cfg_active <= '0;
            r_sel        <= sel_for(position, '0);
        end else begin
            r_state <= w_state_next;
            case (r_state)
                RUN: begin
                    if (cfg_valid_i) begin
                        r_pending <= cfg_i;
                        r_cnt     <= '0;
                    end
                end
                QUIET: begin
                    if (r_cnt == QUIET_LAST) begin
                        r_cfg_active <= r_pending;
                        r_sel        <= sel_for(position, r_pending);
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == SETTLE_LAST) r_cnt <= '0;
                    else                      r_cnt <= r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // North has only n targets, so only the low select bit picks the macro.
    generate
        for (genvar gi = 0; gi <= n; gi++) begin : g_side
            assign w_west_route[gi] = (r_sel == SEL_W'(gi)) ? w_west_sync : '0;
            assign w_east_route[gi] = (r_sel == SEL_W'(gi)) ? w_east_sync : '0;
        end
        for (genvar gi = 0; gi < n; gi++) begin : g_north
            assign w_north_route[gi] = (r_sel[0] == 1'(gi)) ? w_north_sync : '0;
        end
    endgenerate

    // Gating on next state blanks outputs from the acceptance edge and
    // releases them exactly on the edge that re-enters RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_north_buf <= '0;
            r_west_buf  <= '0;
            r_east_buf  <= '0;
        end else if (w_state_next == RUN) begin
            r_north_buf <= w_north_route;
            r_west_buf  <= w_west_route;
            r_east_buf  <= w_east_route;
        end else begin
            r_north_buf <= '0;
            r_west_buf  <= '0;
            r_east_buf  <= '0;
        end
    end

    assign cfg_ready_o  = (r_state == RUN);
    assign quiet_o      = (r_state != RUN);
    assign cfg_active_o = r_cfg_active;
    assign north_i_buf  = r_north_buf;
    assign west_i_buf   = r_west_buf;
    assign east_i_buf   = r_east_buf;

endmodule

// File: tb/tb_vertical_distributor.sv
// Drives one instance per vertical position with shared stimulus and checks
// routing, latency and the quiet/settle handshake against a scoreboard.
module tb_vertical_distributor;

    logic       clk;
    logic       rst;
    logic [3:0] cfg_i;
    logic       cfg_valid;
    logic [9:0] north;
    logic [13:0] west;
    logic [13:0] east;

    logic             rdy [3];
    logic             qt  [3];
    logic [3:0]       act [3];
    logic [1:0][9:0]  nb  [3];
    logic [2:0][13:0] wb  [3];
    logic [2:0][13:0] eb  [3];

    typedef struct {
        int          inst;
        logic [19:0] n;
        logic [41:0] w;
        logic [41:0] e;
        logic [3:0]  act;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        vertical_distributor #(.position(gi)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .cfg_i       (cfg_i),
            .cfg_valid_i (cfg_valid),
            .cfg_ready_o (rdy[gi]),
            .cfg_active_o(act[gi]),
            .quiet_o     (qt[gi]),
            .north_i     (north),
            .west_i      (west),
            .east_i      (east),
            .north_i_buf (nb[gi]),
            .west_i_buf  (wb[gi]),
            .east_i_buf  (eb[gi])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mdl_sel(input int pos, input logic [3:0] cfg);
        int t [3][4] = '{'{0, 2, 1, 2}, '{0, 0, 1, 1}, '{2, 0, 2, 1}};
        if (cfg > 4'd3) return 0;
        return t[pos][cfg];
    endfunction

    function automatic exp_t mdl(input int inst, input logic [3:0] cfg,
                                 input logic [9:0] nv, input logic [13:0] wv,
                                 input logic [13:0] ev);
        exp_t e;
        int   s;
        s      = mdl_sel(inst, cfg);
        e.inst = inst;
        e.n    = '0;
        e.w    = '0;
        e.e    = '0;
        e.w[s*14 +: 14]      = wv;
        e.e[s*14 +: 14]      = ev;
        e.n[(s % 2)*10 +: 10] = nv;
        e.act  = cfg;
        return e;
    endfunction

    task automatic push_exp(input logic [3:0] cfg);
        for (int i = 0; i < 3; i++) sb.push_back(mdl(i, cfg, north, west, east));
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_north%0d", tag, e.inst), 64'(nb[e.inst]), 64'(e.n));
            chk($sformatf("%s_west%0d", tag, e.inst), 64'(wb[e.inst]), 64'(e.w));
            chk($sformatf("%s_east%0d", tag, e.inst), 64'(eb[e.inst]), 64'(e.e));
            chk($sformatf("%s_act%0d", tag, e.inst), 64'(act[e.inst]), 64'(e.act));
            $display("txn %s inst%0d west=%h east=%h north=%h act=%0d",
                     tag, e.inst, wb[e.inst], eb[e.inst], nb[e.inst], act[e.inst]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_zero%0d", tag, i),
                64'({nb[i], wb[i], eb[i]}), 64'(0));
        end
    endtask

    // New pad values; after two edges the old routed data must persist,
    // after the third the new values appear.
    task automatic run_traffic(input string tag, input logic [3:0] cfg, input logic [9:0] nv,
                               input logic [13:0] wv, input logic [13:0] ev,
                               input bit lat_chk);
        if (lat_chk) push_exp(cfg);
        north = nv;
        west  = wv;
        east  = ev;
        tick();
        tick();
        if (lat_chk) sb_check({tag, "_lat"});
        push_exp(cfg);
        tick();
        sb_check(tag);
    endtask

    task automatic do_cfg(input string tag, input logic [3:0] cfg, input bit pulse_bogus);
        int low;
        int guard;
        chk({tag, "_ready_pre"}, 64'(rdy[0]), 64'(1));
        cfg_i     = cfg;
        cfg_valid = 1'b1;
        push_exp(cfg);
        tick();
        cfg_valid = 1'b0;
        chk({tag, "_ready_acc"}, 64'(rdy[0]), 64'(0));
        chk({tag, "_quiet_acc"}, 64'(qt[0]), 64'(1));
        chk_all_zero({tag, "_acc"});
        if (pulse_bogus) begin
            cfg_i     = 4'd2;
            cfg_valid = 1'b1;
        end
        low   = 1;
        guard = 0;
        while (rdy[0] !== 1'b1 && guard < 20) begin
            tick();
            cfg_valid = 1'b0;
            guard++;
            if (rdy[0] !== 1'b1) low++;
        end
        chk({tag, "_ready_low"}, 64'(low), 64'(6));
        chk({tag, "_quiet_run"}, 64'(qt[0]), 64'(0));
        sb_check({tag, "_entry"});
    endtask

    initial begin
        rst       = 1'b1;
        cfg_i     = '0;
        cfg_valid = 1'b0;
        north     = '0;
        west      = '0;
        east      = '0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_quiet%0d", i), 64'(qt[i]), 64'(1));
            chk($sformatf("rst_ready%0d", i), 64'(rdy[i]), 64'(0));
            chk($sformatf("rst_act%0d", i), 64'(act[i]), 64'(0));
        end
        chk_all_zero("rst");
        rst = 1'b0;
        tick();
        chk("settle1_quiet", 64'(qt[0]), 64'(1));
        tick();
        chk("settle2_ready", 64'(rdy[0]), 64'(1));
        chk("settle2_act", 64'(act[0]), 64'(0));

        run_traffic("idle", 4'd0, 10'h2A5, 14'h1234, 14'h0F0F, 1'b0);
        run_traffic("idle2", 4'd0, 10'h155, 14'h2BCD, 14'h3001, 1'b1);

        do_cfg("cfg1", 4'd1, 1'b0);
        run_traffic("cfg1", 4'd1, 10'h3C3, 14'h1111, 14'h2222, 1'b1);

        do_cfg("cfg3", 4'd3, 1'b1);
        run_traffic("cfg3", 4'd3, 10'h0AB, 14'h3ABC, 14'h1DEF, 1'b1);

        do_cfg("cfg3b", 4'd3, 1'b0);

        do_cfg("cfg9", 4'd9, 1'b0);
        run_traffic("cfg9", 4'd9, 10'h123, 14'h0456, 14'h0789, 1'b1);

        // Reset two cycles into QUIET discards the pending request.
        cfg_i     = 4'd2;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_act%0d", i), 64'(act[i]), 64'(0));
            chk($sformatf("midrst_quiet%0d", i), 64'(qt[i]), 64'(1));
        end
        chk_all_zero("midrst");
        tick();
        tick();
        chk("midrst_ready", 64'(rdy[0]), 64'(1));
        run_traffic("post_rst", 4'd0, 10'h3FF, 14'h3FFF, 14'h2AAA, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
